// File: rtl/rs232_rx_fifo_if.sv
// rs232_rx_fifo_if: show-ahead valid/ready pop port of the receive FIFO.
interface rs232_rx_fifo_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    modport master (output rd_data, rd_valid, input rd_ready);
    modport slave  (input rd_data, rd_valid, output rd_ready);
endinterface

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a show-ahead FIFO.
// Define RS232_RX_PARITY_EN for even-parity frames with a parity_err pulse.
module rs232_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         rs232_RXD,
    rs232_rx_fifo_if.master              rd,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         framing_err,
`ifdef RS232_RX_PARITY_EN
    output logic                         parity_err,
`endif
    output logic                         overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef RS232_RX_PARITY_EN
        PARITY,
`endif
        STOP, WAIT_HIGH
    } state_t;

    state_t state_q, state_d;
    logic meta_q, rxs_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0] samp_q, samp_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic fe_q, fe_d, ov_q, ov_d;
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic tick, push, pop, full, wr;
`ifdef RS232_RX_PARITY_EN
    logic par_q, par_d, pe_q, pe_d;
`endif

    assign tick = state_q != IDLE && tcnt_q == TLAST;
    assign full = count_q == (AW + 1)'(FIFO_DEPTH);
    assign pop = rd.rd_valid && rd.rd_ready;
    assign wr = push && (!full || pop);
    assign ov_d = push && full && !pop;

    always_comb begin
        state_d = state_q;
        tcnt_d = (state_q == IDLE || tick) ? '0 : tcnt_q + 1'b1;
        samp_d = tick ? samp_q + 1'b1 : samp_q;
        bit_d = bit_q;
        shift_d = shift_q;
        push = 1'b0;
        fe_d = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_d = par_q;
        pe_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                samp_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: if (tick && samp_q == MID) begin
                samp_d = '0;
                bit_d = '0;
                state_d = rxs_q ? IDLE : DATA;
            end
            DATA: if (tick && samp_q == LAST) begin
                shift_d = {rxs_q, shift_q[7:1]};
                bit_d = bit_q + 1'b1;
`ifdef RS232_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: if (tick && samp_q == LAST) begin
                par_d = rxs_q;
                state_d = STOP;
            end
`endif
            STOP: if (tick && samp_q == LAST) begin
                state_d = rxs_q ? IDLE : WAIT_HIGH;
                fe_d = !rxs_q;
`ifdef RS232_RX_PARITY_EN
                push = rxs_q && !(^{shift_q, par_q});
                pe_d = rxs_q && (^{shift_q, par_q});
`else
                push = rxs_q;
`endif
            end
            WAIT_HIGH: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            meta_q <= 1'b1;
            rxs_q <= 1'b1;
            state_q <= IDLE;
            tcnt_q <= '0;
            samp_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            fe_q <= 1'b0;
            ov_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef RS232_RX_PARITY_EN
            par_q <= 1'b0;
            pe_q <= 1'b0;
`endif
        end else begin
            meta_q <= rs232_RXD;
            rxs_q <= meta_q;
            state_q <= state_d;
            tcnt_q <= tcnt_d;
            samp_q <= samp_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            fe_q <= fe_d;
            ov_q <= ov_d;
            if (wr) mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q <= wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q <= count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
`ifdef RS232_RX_PARITY_EN
            par_q <= par_d;
            pe_q <= pe_d;
`endif
        end
    end

    assign rd.rd_data = mem_q[rd_ptr_q];
    assign rd.rd_valid = count_q != '0;
    assign fifo_count = count_q;
    assign busy = state_q != IDLE;
    assign framing_err = fe_q;
    assign overrun = ov_q;
`ifdef RS232_RX_PARITY_EN
    assign parity_err = pe_q;
`endif
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo: directed checks of the UART receiver and FIFO at 16 clocks per bit, depth 4.
module tb_rs232_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic [2:0] fifo_count;
    logic busy, framing_err, overrun;
    int checks = 0, errors = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
    int rise_cyc = 0, rise_data = 0, rise_count = 0, frame_start = 0;
    logic prev_valid = 1'b0;

    rs232_rx_fifo_if rf();

    rs232_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
        .clk_clk(clk), .reset_reset(rst), .rs232_RXD(rxd), .rd(rf),
        .fifo_count(fifo_count), .busy(busy), .framing_err(framing_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (framing_err && overrun) both_cnt++;
        if (rf.rd_valid && !prev_valid) begin
            rise_cyc = cyc;
            rise_data = int'(rf.rd_data);
            rise_count = int'(fifo_count);
        end
        prev_valid = rf.rd_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] d, input logic stop, input int i);
        if (i < 16) return 1'b0;
        if (i < 144) return d[(i - 16) / 16];
        return stop;
    endfunction

    // Stop bit is sampled on the 155th edge after the start bit is driven; pop_at_stop lines rd_ready up with that edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop);
        frame_start = cyc;
        for (int i = 0; i < 160; i++) begin
            rxd = line_bit(d, stop, i);
            if (i == 154) rf.rd_ready = pop_at_stop;
            if (i == 155) rf.rd_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pop_expect(input logic [7:0] d);
        check("pop_valid", 32'(rf.rd_valid), 32'd1);
        check("pop_data", 32'(rf.rd_data), 32'(d));
        rf.rd_ready = 1'b1;
        @(negedge clk);
        rf.rd_ready = 1'b0;
    endtask

    initial begin
        int n, fe0, ov0;
        rf.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rf.rd_valid), 32'd0);
        check("rst_data", 32'(rf.rd_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fe", 32'(framing_err), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_latency", 32'(rise_cyc - frame_start), 32'd155);
        check("a5_data", 32'(rise_data), 32'hA5);
        check("a5_count", 32'(rise_count), 32'd1);
        check("a5_busy", 32'(busy), 32'd0);
        check("a5_fe", 32'(fe_cnt), 32'd0);
        check("a5_ov", 32'(ov_cnt), 32'd0);
        pop_expect(8'hA5);
        check("a5_empty", 32'(fifo_count), 32'd0);

        n = 0;
        rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rxd = 1'b1;
            @(negedge clk);
            if (busy) n++;
        end
        check("glitch_busy", 32'(n), 32'd8);
        check("glitch_count", 32'(fifo_count), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (640) @(negedge clk);
        check("break_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        check("break_fe", 32'(fe_cnt - fe0), 32'd1);
        check("break_count", 32'(fifo_count), 32'd0);
        check("break_idle", 32'(busy), 32'd0);
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("after_break_count", 32'(fifo_count), 32'd1);
        check("after_break_fe", 32'(fe_cnt - fe0), 32'd1);
        pop_expect(8'h11);

        ov0 = ov_cnt;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0);
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_ov", 32'(ov_cnt - ov0), 32'd0);
        send_frame(8'h05, 1'b1, 1'b0);
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        for (int b = 1; b <= 4; b++) pop_expect(8'(b));
        check("ovr_drained", 32'(rf.rd_valid), 32'd0);

        send_frame(8'h10, 1'b1, 1'b0);
        send_frame(8'h20, 1'b1, 1'b0);
        send_frame(8'h30, 1'b1, 1'b0);
        send_frame(8'h40, 1'b1, 1'b0);
        ov0 = ov_cnt;
        send_frame(8'h77, 1'b1, 1'b1);
        check("simul_count", 32'(fifo_count), 32'd4);
        check("simul_ov", 32'(ov_cnt - ov0), 32'd0);
        pop_expect(8'h20);
        pop_expect(8'h30);
        pop_expect(8'h40);
        pop_expect(8'h77);
        check("simul_empty", 32'(fifo_count), 32'd0);

        send_frame(8'h99, 1'b1, 1'b0);
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int i = 0; i < 70; i++) begin
            rxd = line_bit(8'h5A, 1'b1, i);
            @(negedge clk);
        end
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rf.rd_valid), 32'd0);
        check("mid_rst_data", 32'(rf.rd_data), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_fe", 32'(framing_err), 32'd0);
        check("mid_rst_ov", 32'(overrun), 32'd0);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_no_push", 32'(fifo_count), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("c3_count", 32'(fifo_count), 32'd1);
        check("mid_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        pop_expect(8'hC3);
        check("fe_ov_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
- Standalone UART receiver with a small receive FIFO, built as the far end of the nios_system rs232_TXD serial line (8N1).
- Used on board-level test harnesses and peer FPGA logic to decode the byte stream the Nios core transmits.
- Presents received bytes through a valid/ready pop interface.
- Runs on the system clock and uses 16x oversampling.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit. Fixed at 16; any other value is unsupported.
- FIFO_DEPTH, 16: receive FIFO entries. Must be a power of 2 and at least 2.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE): clocks per sample tick, integer division. Must be at least 1. Default is 27.

Ports:
- clk_clk  input  1  system clock.
- reset_reset  input  1  synchronous, active-high reset.
- rs232_RXD  input  1  asynchronous serial line. Idle level is high.
- rd_data  output  8  byte at the FIFO head (show-ahead).
- rd_valid  output  1  FIFO is non-empty.
- rd_ready  input  1  consumer accepts rd_data.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  output  1  receiver is not in IDLE.
- framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a valid byte is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, reset_reset=1 at a clk_clk edge):
  - Synchronizer flops are set to 1, state to IDLE, tick/sample/bit counters to 0, FIFO pointers and count to 0.
  - Outputs: rd_valid=0, rd_data=0, fifo_count=0, busy=0, framing_err=0, overrun=0.
  - Reset asserted mid-frame aborts the frame. No byte is pushed and no error pulse is produced.
- Input path: rs232_RXD goes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick generator:
  - A counter counts 0..DIV-1 and emits tick on the DIV-1 cycle.
  - It is held at 0 in IDLE, so sampling phase is aligned to start-bit detection.
- State machine:
  - IDLE: when rxs=0, go to START and clear the sample counter.
  - START: on the 8th tick (mid-bit), if rxs=1 treat it as a glitch and go to IDLE. Otherwise go to DATA with the sample and bit counters cleared.
  - DATA: every 16th tick, shift rxs into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: on the 16th tick, sample rxs.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse framing_err, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. A break condition therefore produces exactly one framing_err.
- busy=1 in every state except IDLE.
- Latency: the pushed byte appears on rd_data, with rd_valid=1, on the cycle after the stop-bit sample edge.
- FIFO:
  - Synchronous, show-ahead. rd_valid = (count != 0). Pop happens when rd_valid && rd_ready.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH.
  - Full, push with no pop: the byte is dropped, overrun pulses for one cycle, and FIFO contents are unchanged.
  - Full, push and pop in the same cycle: both happen, count stays at FIFO_DEPTH, no overrun.
  - Empty, rd_ready=1: no effect. rd_data holds its last value.
  - Push and pop on the same cycle at any other fill level: count is unchanged.
- framing_err and overrun are never asserted in the same cycle.

Optional Feature:
- Macro: RS232_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP and samples an even-parity bit on its 16th tick.
  - Port parity_err (output, 1) is added. It pulses one cycle at the stop-bit sample when the parity mismatched and the stop bit was 1.
  - The byte is dropped on parity error, and overrun is not evaluated for that byte.
- When not defined: frames are 8N1, the PARITY state and parity_err port do not exist, and behaviour is exactly as above.

Test Plan:
- Setup for all cases: CLK_HZ=1600000, BAUD=100000, so DIV=1 and 16 clocks per bit.
- Single byte: send 0xA5 8N1, rd_ready=0. Required: rd_data=0xA5, rd_valid=1, fifo_count=1 exactly one cycle after the stop-bit sample. No error pulses. busy returns to 0.
- Glitch rejection: drive rxs low for 4 clocks, then high. Required: state returns to IDLE, no push, busy=1 for no more than 10 cycles.
- Framing and break: send 0x3C with stop bit 0, then hold the line low for 40 bit-times, then release. Required: exactly one framing_err pulse, fifo_count stays 0. The next frame 0x11 is received correctly.
- Overrun with FIFO_DEPTH=4, rd_ready=0: send 0x01..0x05. Required: fifo_count=4, one overrun pulse on byte 0x05. Popping yields 0x01,0x02,0x03,0x04 in order.
- Simultaneous full push/pop: FIFO full, rd_ready=1 on the stop-sample+1 cycle of 0x77. Required: no overrun, fifo_count stays 4, 0x77 is last out.
- Reset mid-frame: assert reset_reset during DATA bit 3 of 0x5A. Required: all outputs are 0 on the next edge, no push. A following 0xC3 is received correctly.
